stq_fwd: RTL
============

Name: stq_fwd

Overview:
Parametrised store queue that succeeds the fixed 16-entry store side of the load-store queue. It accepts stores in program order from rename and snoops writeback for base and data operands. It generates addresses internally, holds stores until the ROB retires them, then drains them in order to the dcache as lane-aligned, byte-masked writes. New behaviour: a combinational store-to-load forwarding/conflict port, a configurable depth, and occupancy outputs.

Parameters:
DEPTH, 16, number of entries; power of two, at least 2.
IDW, $clog2(DEPTH), entry index width; the sqid is {pol, idx}, IDW+1 bits.
ROBW, 7, ROB tag width used to match writeback.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ins_valid  in  1  insert a store from rename
ins_ready  out  1  queue not full
ins_size  in  2  size: 0=byte, 1=half, 2=word
ins_base_rdy  in  1  base operand valid; otherwise ins_base[ROBW-1:0] is a ROB tag
ins_base  in  32  base value or tag
ins_data_rdy  in  1  store data valid; otherwise ins_data[ROBW-1:0] is a ROB tag
ins_data  in  32  data value or tag
ins_imm  in  32  address offset
ins_sqid  out  IDW+1  sqid assigned to this insert (= tail)
wb_valid  in  1  writeback broadcast
wb_robid  in  ROBW  writeback tag
wb_result  in  32  writeback value
ret_store  in  1  ROB retires the oldest unretired store
flush  in  1  squash all unretired stores
ld_req  in  1  forwarding query valid
ld_addr  in  32  load byte address
ld_size  in  2  load size
ld_sqid  in  IDW+1  tail snapshot taken at load dispatch
ld_fwd  out  1  full forward available
ld_fwd_data  out  32  lane-aligned forwarded data
ld_conflict  out  1  load must wait
dc_req  out  1  drain request
dc_ready  in  1  dcache accepts
dc_addr  out  32  word-aligned address
dc_wdata  out  32  lane-aligned data
dc_wmask  out  4  byte enables
sq_empty  out  1  no valid entries
sq_count  out  IDW+1  number of valid entries

Behaviour:
- Three pointers, each {pol, idx}: head (drain), mid (retire), tail (insert). full = idx equal and pol differ; empty = head == tail.
- Reset: all pointers 0, all valid bits 0. Outputs: ins_ready=1, sq_empty=1, sq_count=0, dc_req=0, ld_fwd=0, ld_conflict=0.
- Insert beat = ins_valid & ins_ready & ~flush. Writes entry[tail] and increments tail. If wb_valid matches a not-ready operand tag in the same cycle, wb_result is captured as that operand and the operand is marked ready.
- Snoop: each valid entry with a not-ready base or data whose tag equals wb_robid captures wb_result that cycle.
- Addrgen: one entry per cycle, the oldest valid entry with base ready and address not ready. Addr = base + imm, mod 2^32. wmask = size mask << addr[1:0]; wdata = data << 8*addr[1:0]. addr_rdy is set at the clock edge. An entry inserted with base ready at cycle N has addr_rdy at N+2.
- wdata/wmask are recomputed whenever data becomes ready after addrgen.
- Misaligned accesses (half at addr[0]=1, word at addr[1:0]!=0): wmask truncates at the word boundary. No fault is raised; faults are detected upstream.
- Retire: ret_store sets the retired bit of entry[mid] and increments mid. ret_store while mid == tail is illegal; the design asserts on it.
- Drain: dc_req = entry[head] valid & retired & addr_rdy & data_rdy & ~flush. Beat = dc_req & dc_ready; the beat clears the entry and increments head.
- Flush: tail <= mid; unretired entries are invalidated; retired entries are kept and continue draining.
- flush and ret_store in the same cycle: the retire takes effect first, so tail <= mid+1.
- Insert during flush is dropped; ins_ready is still reported.
- Forwarding (combinational, same cycle):
  - Older set = valid entries from head up to, but excluding, ld_sqid.
  - Scan the older set youngest first. An entry with addr not ready gives ld_conflict=1.
  - A word match with overlapping masks: if the store mask covers the load mask, ld_fwd=1 and ld_fwd_data = store wdata; otherwise ld_conflict=1.
  - The first hit decides the result. No hit gives both outputs 0.
  - Both outputs are 0 when ld_req=0.
  - An entry draining in the same cycle still participates.
- sq_count = tail - head, computed modulo 2*DEPTH.

Decomposition:
- Shared package: size encodings (SZ_B/SZ_H/SZ_W), a size-to-mask function, a lane-shift function, and the sqid type.
- One natural sub-module: stq_fwd_sel, a youngest-first circular priority selector parametrised by DEPTH. It is reused for both the forwarding scan and the oldest-first addrgen pick (reversed).

Test Plan:
1. Insert SW (base=0x1000 ready, imm=4, data=0xAABBCCDD ready), ret_store, dc_ready=1 -> dc_req, dc_addr=0x1004, wmask=0xF, wdata=0xAABBCCDD; sq_empty returns to 1.
2. SB with data tag 5, base 0x2003; then wb robid=5 result=0x11 -> after drain wmask=0x8, wdata=0x11000000.
3. SW to 0x3000 data=0x12345678; LH 0x3002 with ld_sqid after the store -> ld_fwd=1, ld_fwd_data=0x12345678. Same query with ld_sqid equal to the store's sqid -> both outputs 0.
4. SB 0x4001; LW 0x4000 younger -> ld_conflict=1. Store with base unready; any younger load -> ld_conflict=1.
5. Fill DEPTH stores -> ins_ready=0, sq_count=DEPTH. Retire 3, flush -> tail=mid, sq_count=3, the 3 entries drain, and the pointers wrap correctly across pol.
6. Assert rst mid-drain (dc_req=1) -> dc_req=0 immediately (async), sq_empty=1; flush+ret_store in the same cycle -> 1 extra entry retained.

Source files
------------

// File: rtl/stq_fwd_pkg.sv
// Shared types and lane helpers for the store queue: size encodings, byte-mask and
// lane-alignment functions, and the default sqid type.
package stq_fwd_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int unsigned DEF_DEPTH = 16;

    typedef logic [$clog2(DEF_DEPTH):0] sqid_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Shifting a 4-bit mask drops lanes past byte 3, so misaligned accesses truncate.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size_mask(size) << off;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

endpackage

// File: rtl/stq_fwd_sel.sv
// Circular priority selector: finds the first set request scanning downward from top-1,
// wrapping, i.e. youngest-first when top is one past the youngest entry.
module stq_fwd_sel #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    input  logic [IDW-1:0]   top,
    output logic             found,
    output logic [IDW-1:0]   sel
);

    logic [IDW-1:0] pos;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        pos   = '0;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            pos = top - IDW'(k);
            if (!found && req[pos]) begin
                found = 1'b1;
                sel   = pos;
            end
        end
    end

endmodule

// File: rtl/stq_fwd.sv
// Store queue with writeback snooping, in-queue address generation, in-order drain of
// retired stores to the dcache, and a combinational store-to-load forwarding port.
module stq_fwd
    import stq_fwd_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDW   = $clog2(DEPTH),
    parameter int unsigned ROBW  = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ins_valid,
    output logic            ins_ready,
    input  logic [1:0]      ins_size,
    input  logic            ins_base_rdy,
    input  logic [31:0]     ins_base,
    input  logic            ins_data_rdy,
    input  logic [31:0]     ins_data,
    input  logic [31:0]     ins_imm,
    output logic [IDW:0]    ins_sqid,
    input  logic            wb_valid,
    input  logic [ROBW-1:0] wb_robid,
    input  logic [31:0]     wb_result,
    input  logic            ret_store,
    input  logic            flush,
    input  logic            ld_req,
    input  logic [31:0]     ld_addr,
    input  logic [1:0]      ld_size,
    input  logic [IDW:0]    ld_sqid,
    output logic            ld_fwd,
    output logic [31:0]     ld_fwd_data,
    output logic            ld_conflict,
    output logic            dc_req,
    input  logic            dc_ready,
    output logic [31:0]     dc_addr,
    output logic [31:0]     dc_wdata,
    output logic [3:0]      dc_wmask,
    output logic            sq_empty,
    output logic [IDW:0]    sq_count
);

    logic [IDW:0]     head_q, mid_q, tail_q, head_d, mid_d, tail_d;
    logic [DEPTH-1:0] valid_q, ret_q, brdy_q, drdy_q, ardy_q;
    logic [DEPTH-1:0] valid_d, ret_d, brdy_d, drdy_d, ardy_d;
    logic [31:0]      base_q [DEPTH];
    logic [31:0]      imm_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      addr_q [DEPTH];
    logic [1:0]       size_q [DEPTH];

    logic [IDW-1:0] h_idx, m_idx, t_idx;
    logic           full, ins_fire, dc_fire, ins_base_hit, ins_data_hit;
    logic [DEPTH-1:0] base_hit, data_hit;

    assign h_idx = head_q[IDW-1:0];
    assign m_idx = mid_q[IDW-1:0];
    assign t_idx = tail_q[IDW-1:0];

    assign full      = (h_idx == t_idx) && (head_q[IDW] != tail_q[IDW]);
    assign ins_ready = ~full;
    assign ins_fire  = ins_valid & ins_ready & ~flush;
    assign ins_sqid  = tail_q;
    assign sq_empty  = (head_q == tail_q);
    assign sq_count  = tail_q - head_q;

    assign ins_base_hit = wb_valid & ~ins_base_rdy & (ins_base[ROBW-1:0] == wb_robid);
    assign ins_data_hit = wb_valid & ~ins_data_rdy & (ins_data[ROBW-1:0] == wb_robid);

    always_comb begin
        base_hit = '0;
        data_hit = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            base_hit[i] = wb_valid & valid_q[i] & ~brdy_q[i] &
                          (base_q[i][ROBW-1:0] == wb_robid);
            data_hit[i] = wb_valid & valid_q[i] & ~drdy_q[i] &
                          (data_q[i][ROBW-1:0] == wb_robid);
        end
    end

    // Addrgen picks oldest-first by running the selector over the bit-reversed queue.
    logic [DEPTH-1:0] ag_req, ag_req_rev;
    logic [IDW-1:0]   ag_top, ag_sel_rev, ag_idx;
    logic             ag_found;

    assign ag_req = valid_q & brdy_q & ~ardy_q;
    assign ag_top = '0 - h_idx;
    assign ag_idx = ~ag_sel_rev;

    always_comb begin
        ag_req_rev = '0;
        for (int i = 0; i < int'(DEPTH); i++) ag_req_rev[i] = ag_req[int'(DEPTH) - 1 - i];
    end

    stq_fwd_sel #(.DEPTH(DEPTH), .IDW(IDW)) u_ag_sel (
        .req   (ag_req_rev),
        .top   (ag_top),
        .found (ag_found),
        .sel   (ag_sel_rev)
    );

    assign dc_req   = valid_q[h_idx] & ret_q[h_idx] & ardy_q[h_idx] & drdy_q[h_idx] & ~flush;
    assign dc_fire  = dc_req & dc_ready;
    assign dc_addr  = {addr_q[h_idx][31:2], 2'b00};
    assign dc_wdata = lane_data(data_q[h_idx], addr_q[h_idx][1:0]);
    assign dc_wmask = lane_mask(size_q[h_idx], addr_q[h_idx][1:0]);

    // Forwarding: older set is [head, ld_sqid); scan it youngest first.
    logic [DEPTH-1:0] f_req;
    logic [IDW:0]     f_lim;
    logic [IDW-1:0]   f_off, f_sel;
    logic [3:0]       f_lmask, f_smask, f_mask;
    logic             f_found, f_cover;

    assign f_lmask = lane_mask(ld_size, ld_addr[1:0]);
    assign f_lim   = ld_sqid - head_q;

    always_comb begin
        f_req   = '0;
        f_off   = '0;
        f_smask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            f_off    = IDW'(i) - h_idx;
            f_smask  = lane_mask(size_q[i], addr_q[i][1:0]);
            f_req[i] = valid_q[i] && ({1'b0, f_off} < f_lim) &&
                       (!ardy_q[i] || ((addr_q[i][31:2] == ld_addr[31:2]) &&
                                       ((f_smask & f_lmask) != 4'b0000)));
        end
    end

    stq_fwd_sel #(.DEPTH(DEPTH), .IDW(IDW)) u_fwd_sel (
        .req   (f_req),
        .top   (ld_sqid[IDW-1:0]),
        .found (f_found),
        .sel   (f_sel)
    );

    // A covering store whose data is still a tag cannot forward, so it must stall the load.
    assign f_mask      = lane_mask(size_q[f_sel], addr_q[f_sel][1:0]);
    assign f_cover     = ardy_q[f_sel] && drdy_q[f_sel] && ((f_mask & f_lmask) == f_lmask);
    assign ld_fwd      = ld_req & f_found & f_cover;
    assign ld_conflict = ld_req & f_found & ~f_cover;
    assign ld_fwd_data = lane_data(data_q[f_sel], addr_q[f_sel][1:0]);

    assign head_d = dc_fire ? head_q + 1'b1 : head_q;
    assign mid_d  = ret_store ? mid_q + 1'b1 : mid_q;
    assign tail_d = flush ? mid_d : (ins_fire ? tail_q + 1'b1 : tail_q);

    always_comb begin
        valid_d = valid_q;
        ret_d   = ret_q;
        brdy_d  = brdy_q | base_hit;
        drdy_d  = drdy_q | data_hit;
        ardy_d  = ardy_q;
        if (ag_found) ardy_d[ag_idx] = 1'b1;
        if (ret_store) ret_d[m_idx] = 1'b1;
        if (dc_fire) begin
            valid_d[h_idx] = 1'b0;
            ret_d[h_idx]   = 1'b0;
        end
        if (flush) valid_d = valid_d & ret_d;
        if (ins_fire) begin
            valid_d[t_idx] = 1'b1;
            ret_d[t_idx]   = 1'b0;
            brdy_d[t_idx]  = ins_base_rdy | ins_base_hit;
            drdy_d[t_idx]  = ins_data_rdy | ins_data_hit;
            ardy_d[t_idx]  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            mid_q   <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            ret_q   <= '0;
            brdy_q  <= '0;
            drdy_q  <= '0;
            ardy_q  <= '0;
        end else begin
            head_q  <= head_d;
            mid_q   <= mid_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            ret_q   <= ret_d;
            brdy_q  <= brdy_d;
            drdy_q  <= drdy_d;
            ardy_q  <= ardy_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ins_fire && (t_idx == IDW'(i))) begin
                base_q[i] <= ins_base_hit ? wb_result : ins_base;
                data_q[i] <= ins_data_hit ? wb_result : ins_data;
                imm_q[i]  <= ins_imm;
                size_q[i] <= ins_size;
            end else begin
                if (base_hit[i]) base_q[i] <= wb_result;
                if (data_hit[i]) data_q[i] <= wb_result;
            end
            if (ag_found && (ag_idx == IDW'(i))) addr_q[i] <= base_q[i] + imm_q[i];
        end
    end

    ret_in_range: assert property (@(posedge clk) disable iff (rst)
                                   !(ret_store && (mid_q == tail_q)));

endmodule
